// File: rtl/log_mult_arbiter_if.sv
// log_mult_arbiter_if: request, multiplier and result signals of the shared log multiplier arbiter
interface log_mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0] mult_a;
  logic [WIDTH-1:0] mult_b;
  logic [2*WIDTH-1:0] mult_result;
  logic out_valid;
  logic out_ready;
  logic [2*WIDTH-1:0] out_result;
  logic [ID_W-1:0] out_id;
  modport master (
    output req_valid, req_a, req_b, mult_result, out_ready,
    input req_ready, mult_a, mult_b, out_valid, out_result, out_id
  );
  modport slave (
    input req_valid, req_a, req_b, mult_result, out_ready,
    output req_ready, mult_a, mult_b, out_valid, out_result, out_id
  );
endinterface

// File: rtl/log_mult_arbiter.sv
// log_mult_arbiter: round-robin sharing of one external log multiplier with zero-operand bypass
module log_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W = 2
) (
  input logic clk,
  input logic rst,
  log_mult_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] rr_ptr, gnt_id, gnt, out_id;
  logic [WIDTH-1:0] op_a, op_b;
  logic [2*WIDTH-1:0] out_result;
  logic out_valid, found;
  // descending scan so the requester closest to rr_ptr is written last and wins
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        gnt = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (found ? CALC : IDLE) :
              state == CALC ? OUT :
              (bus.out_ready ? IDLE : OUT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      gnt_id <= '0;
      op_a <= '0;
      op_b <= '0;
      out_result <= '0;
      out_id <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) begin
        op_a <= bus.req_a[gnt*WIDTH +: WIDTH];
        op_b <= bus.req_b[gnt*WIDTH +: WIDTH];
        gnt_id <= gnt;
      end
      if (state == CALC) begin
        out_result <= (op_a == '0 || op_b == '0) ? '0 : bus.mult_result;
        out_id <= gnt_id;
        out_valid <= 1'b1;
      end
      if (state == OUT && bus.out_ready) begin
        out_valid <= 1'b0;
        rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end
  assign bus.req_ready = (state == IDLE && found) ? NUM_REQ'(1) << gnt : '0;
  assign bus.mult_a = op_a;
  assign bus.mult_b = op_b;
  assign bus.out_valid = out_valid;
  assign bus.out_result = out_result;
  assign bus.out_id = out_id;
endmodule
